// File: rtl/branch_predictor.sv
// Tournament branch direction predictor: per-PC local history + gshare global
// components, arbitrated by a per-PC 2-bit chooser. Lookup is combinational; training is registered.
module branch_predictor #(
  parameter int PC_WIDTH  = 32,
  parameter int LHT_IDX_W = 6,
  parameter int LHR_W     = 8,
  parameter int GHR_W     = 8,
  parameter int CHS_IDX_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] F_PC_i,
  output logic                F_predict_o,
  output logic                F_local_predict_o,
  output logic                F_global_predict_o,
  output logic [LHR_W-1:0]    F_lhr_o,
  output logic [GHR_W-1:0]    F_ghr_o,
  input  logic                D_train_valid_i,
  input  logic [PC_WIDTH-1:0] FD_PC_i,
  input  logic                FD_train_predict_i,
  input  logic                FD_train_local_predict_i,
  input  logic                FD_train_global_predict_i,
  input  logic [LHR_W-1:0]    FD_lhr_i,
  input  logic [GHR_W-1:0]    FD_ghr_i,
  input  logic                D_train_taken_i,
  input  logic                D_train_local_taken_i,
  input  logic                D_train_global_taken_i
);

  localparam int LHT_N  = 1 << LHT_IDX_W;
  localparam int LPHT_N = 1 << LHR_W;
  localparam int GPHT_N = 1 << GHR_W;
  localparam int CHS_N  = 1 << CHS_IDX_W;

  logic [LHR_W-1:0] lht     [LHT_N];
  logic [1:0]       lpht    [LPHT_N];
  logic [1:0]       gpht    [GPHT_N];
  logic [1:0]       chooser [CHS_N];
  logic [GHR_W-1:0] ghr;

  logic [LHT_IDX_W-1:0] f_lht_idx, d_lht_idx;
  logic [CHS_IDX_W-1:0] f_chs_idx, d_chs_idx;
  logic [GHR_W-1:0]     f_gpht_idx, d_gpht_idx;
  logic [LHR_W-1:0]     f_lhr;
  logic                 f_local, f_global;
  logic                 actual;
  logic                 chooser_train;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

  // Lookup path
  always_comb begin
    f_lht_idx  = F_PC_i[LHT_IDX_W+1:2];
    f_chs_idx  = F_PC_i[CHS_IDX_W+1:2];
    f_gpht_idx = ghr ^ F_PC_i[GHR_W+1:2];
    f_lhr      = lht[f_lht_idx];
    f_local    = lpht[f_lhr][1];
    f_global   = gpht[f_gpht_idx][1];
  end

  assign F_local_predict_o  = f_local;
  assign F_global_predict_o = f_global;
  assign F_predict_o        = chooser[f_chs_idx][1] ? f_global : f_local;
  assign F_lhr_o            = f_lhr;
  assign F_ghr_o            = ghr;

  // Training path: indices come from the echoed snapshots, not current history
  always_comb begin
    d_lht_idx     = FD_PC_i[LHT_IDX_W+1:2];
    d_chs_idx     = FD_PC_i[CHS_IDX_W+1:2];
    d_gpht_idx    = FD_ghr_i ^ FD_PC_i[GHR_W+1:2];
    actual        = ~(FD_train_predict_i ^ D_train_taken_i);
    chooser_train = D_train_valid_i && (D_train_local_taken_i != D_train_global_taken_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LPHT_N; i++) lpht[i] <= 2'b01;
    end else if (D_train_valid_i) begin
      lpht[FD_lhr_i] <= sat_update(lpht[FD_lhr_i], actual);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < GPHT_N; i++) gpht[i] <= 2'b01;
    end else if (D_train_valid_i) begin
      gpht[d_gpht_idx] <= sat_update(gpht[d_gpht_idx], actual);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LHT_N; i++) lht[i] <= '0;
    end else if (D_train_valid_i) begin
      lht[d_lht_idx] <= {FD_lhr_i[LHR_W-2:0], actual};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (D_train_valid_i) begin
      ghr <= {ghr[GHR_W-2:0], actual};
    end
  end

  // Count up toward global when only global was right, down toward local otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHS_N; i++) chooser[i] <= 2'b01;
    end else if (chooser_train) begin
      chooser[d_chs_idx] <= sat_update(chooser[d_chs_idx], D_train_global_taken_i);
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{F_PC_i, FD_PC_i, FD_train_local_predict_i, FD_train_global_predict_i};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a table-level reference model predicts each lookup,
// expectations are queued at drive time and compared on the following falling edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] F_PC_i;
  logic        F_predict_o, F_local_predict_o, F_global_predict_o;
  logic [7:0]  F_lhr_o, F_ghr_o;
  logic        D_train_valid_i;
  logic [31:0] FD_PC_i;
  logic        FD_train_predict_i, FD_train_local_predict_i, FD_train_global_predict_i;
  logic [7:0]  FD_lhr_i, FD_ghr_i;
  logic        D_train_taken_i, D_train_local_taken_i, D_train_global_taken_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [1:0] m_lpht [256];
  logic [1:0] m_gpht [256];
  logic [1:0] m_chs  [256];
  logic [7:0] m_lht  [64];
  logic [7:0] m_ghr;

  logic [18:0] sb [$];

  always #5 clk = ~clk;

  branch_predictor #(
    .PC_WIDTH (32),
    .LHT_IDX_W(6),
    .LHR_W    (8),
    .GHR_W    (8),
    .CHS_IDX_W(8)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .F_PC_i                   (F_PC_i),
    .F_predict_o              (F_predict_o),
    .F_local_predict_o        (F_local_predict_o),
    .F_global_predict_o       (F_global_predict_o),
    .F_lhr_o                  (F_lhr_o),
    .F_ghr_o                  (F_ghr_o),
    .D_train_valid_i          (D_train_valid_i),
    .FD_PC_i                  (FD_PC_i),
    .FD_train_predict_i       (FD_train_predict_i),
    .FD_train_local_predict_i (FD_train_local_predict_i),
    .FD_train_global_predict_i(FD_train_global_predict_i),
    .FD_lhr_i                 (FD_lhr_i),
    .FD_ghr_i                 (FD_ghr_i),
    .D_train_taken_i          (D_train_taken_i),
    .D_train_local_taken_i    (D_train_local_taken_i),
    .D_train_global_taken_i   (D_train_global_taken_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [7:0] lht_of(input logic [31:0] pc);
    return m_lht[pc[7:2]];
  endfunction

  function automatic logic [18:0] model_lookup(input logic [31:0] pc);
    logic [7:0] lhr, gi;
    logic       l, g, c;
    lhr = m_lht[pc[7:2]];
    gi  = m_ghr ^ pc[9:2];
    l   = m_lpht[lhr][1];
    g   = m_gpht[gi][1];
    c   = m_chs[pc[9:2]][1];
    return {(c ? g : l), l, g, lhr, m_ghr};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_lpht[i] = 2'b01;
      m_gpht[i] = 2'b01;
      m_chs[i]  = 2'b01;
    end
    for (int i = 0; i < 64; i++) m_lht[i] = 8'h00;
    m_ghr = 8'h00;
  endtask

  task automatic model_train(input logic [31:0] tpc, input logic tp, input logic [7:0] tl,
                             input logic [7:0] tg, input logic tt, input logic tlt, input logic tgt);
    logic       act;
    logic [7:0] gi;
    act = ~(tp ^ tt);
    gi  = tg ^ tpc[9:2];
    m_lpht[tl]       = sat(m_lpht[tl], act);
    m_gpht[gi]       = sat(m_gpht[gi], act);
    m_lht[tpc[7:2]]  = {tl[6:0], act};
    m_ghr            = {m_ghr[6:0], act};
    if (tlt != tgt) m_chs[tpc[9:2]] = sat(m_chs[tpc[9:2]], tgt);
  endtask

  // One cycle: drive lookup + optional training, compare at negedge, apply model at posedge.
  task automatic step(input logic [31:0] pc, input logic v, input logic [31:0] tpc,
                      input logic tp, input logic tlp, input logic tgp,
                      input logic [7:0] tl, input logic [7:0] tg,
                      input logic tt, input logic tlt, input logic tgt);
    logic [18:0] got;
    F_PC_i                    = pc;
    D_train_valid_i           = v;
    FD_PC_i                   = tpc;
    FD_train_predict_i        = tp;
    FD_train_local_predict_i  = tlp;
    FD_train_global_predict_i = tgp;
    FD_lhr_i                  = tl;
    FD_ghr_i                  = tg;
    D_train_taken_i           = tt;
    D_train_local_taken_i     = tlt;
    D_train_global_taken_i    = tgt;
    sb.push_back(model_lookup(pc));
    @(negedge clk);
    got = {F_predict_o, F_local_predict_o, F_global_predict_o, F_lhr_o, F_ghr_o};
    check("lookup", {13'd0, got}, {13'd0, sb.pop_front()});
    @(posedge clk);
    if (v) model_train(tpc, tp, tl, tg, tt, tlt, tgt);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tr(input logic [31:0] pc, input logic tp, input logic tt,
                    input logic tlt, input logic tgt, input logic [7:0] tl);
    step(pc, 1'b1, pc, tp, tp, tp, tl, m_ghr, tt, tlt, tgt);
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic [2:0] exp_plg);
    F_PC_i          = pc;
    D_train_valid_i = 1'b0;
    #1;
    check(tag, {29'd0, F_predict_o, F_local_predict_o, F_global_predict_o}, {29'd0, exp_plg});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] prev;
    logic [31:0] prev_pc, pc;
    logic [31:0] pcs [6];

    rst_n = 1'b0;
    F_PC_i = 32'h100;
    D_train_valid_i = 1'b0;
    FD_PC_i = '0;
    FD_train_predict_i = 1'b0;
    FD_train_local_predict_i = 1'b0;
    FD_train_global_predict_i = 1'b0;
    FD_lhr_i = '0;
    FD_ghr_i = '0;
    D_train_taken_i = 1'b0;
    D_train_local_taken_i = 1'b0;
    D_train_global_taken_i = 1'b0;
    model_reset();

    // Reset state
    #3;
    check("rst_predict", {31'd0, F_predict_o}, 32'd0);
    check("rst_local",   {31'd0, F_local_predict_o}, 32'd0);
    check("rst_global",  {31'd0, F_global_predict_o}, 32'd0);
    check("rst_lhr",     {24'd0, F_lhr_o}, 32'd0);
    check("rst_ghr",     {24'd0, F_ghr_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two taken resolutions of PC 0x100, both components wrong
    idle(32'h100);
    tr(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tr(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    idle(32'h100);
    F_PC_i = 32'h100;
    #1;
    check("hist_lhr", {24'd0, F_lhr_o}, 32'h3);
    check("hist_ghr", {24'd0, F_ghr_o}, 32'h3);

    // Saturation of LPHT[0x55]; 0x504 is primed so its lookup reads that counter
    tr(32'h504, 1'b1, 1'b1, 1'b1, 1'b1, 8'h2A);
    for (int i = 0; i < 5; i++) tr(32'h608, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    tr(32'h608, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    idle(32'h504);
    probe("sat_hi", 32'h504, {m_chs[8'h41][1] ? m_gpht[m_ghr ^ 8'h41][1] : 1'b1, 1'b1, m_gpht[m_ghr ^ 8'h41][1]});
    for (int i = 0; i < 5; i++) tr(32'h608, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    tr(32'h608, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    idle(32'h504);
    probe("sat_lo", 32'h504, {m_chs[8'h41][1] ? m_gpht[m_ghr ^ 8'h41][1] : 1'b0, 1'b0, m_gpht[m_ghr ^ 8'h41][1]});

    // Chooser moves toward global, then global PHT made taken while local stays weak
    for (int i = 0; i < 3; i++) tr(32'h200, 1'b0, 1'b1, 1'b0, 1'b1, lht_of(32'h200));
    for (int i = 0; i < 10; i++) tr(32'h200, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
    idle(32'h200);
    probe("chooser_global", 32'h200, 3'b101);

    // Same-cycle lookup and training of one PC
    idle(32'h300);
    step(32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, lht_of(32'h300), m_ghr, 1'b1, 1'b0, 1'b1);
    step(32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, lht_of(32'h300), m_ghr, 1'b1, 1'b0, 1'b1);
    idle(32'h300);

    // Pipelined random traffic, training echoes the previous cycle's snapshot
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
    pcs[3] = 32'h504; pcs[4] = 32'h608; pcs[5] = 32'h70C;
    prev_pc = 32'h100;
    prev = model_lookup(prev_pc);
    for (int i = 0; i < 300; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? $urandom() : pcs[$urandom_range(0, 5)];
      step(pc, 1'($urandom_range(0, 1)), prev_pc, prev[18], prev[17], prev[16], prev[15:8], prev[7:0],
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      prev_pc = pc;
      prev = model_lookup(pc);
    end

    // Reset asserted while a training update is pending
    F_PC_i = 32'h608;
    D_train_valid_i = 1'b1;
    FD_PC_i = 32'h608;
    FD_train_predict_i = 1'b1;
    FD_lhr_i = 8'h55;
    FD_ghr_i = 8'h00;
    D_train_taken_i = 1'b1;
    D_train_local_taken_i = 1'b0;
    D_train_global_taken_i = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_out", {13'd0, F_predict_o, F_local_predict_o, F_global_predict_o, F_lhr_o, F_ghr_o}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", {13'd0, F_predict_o, F_local_predict_o, F_global_predict_o, F_lhr_o, F_ghr_o}, 32'd0);
    @(negedge clk);
    D_train_valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(32'h608);
    idle(32'h504);
    idle(32'h200);
    idle(32'h100);
    F_PC_i = 32'h200;
    #1;
    check("post_rst_lhr", {24'd0, F_lhr_o}, 32'd0);
    check("post_rst_predict", {31'd0, F_predict_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
